// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trng_pkg
// Description : Shared types and default sizes for the TRNG post-processor.
// Revision    : 1.0 - initial release
// ============================================================================
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        FAIL   = 2'd3
    } state_t;

    localparam int DEF_WORD_WIDTH    = 32;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_WARMUP_CYCLES = 16;
    localparam int DEF_REP_LIMIT     = 32;

endpackage
`default_nettype wire

// File: rtl/trng_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trng_fifo
// Description : Synchronous FIFO with flush; head word shown as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_fifo
#(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot in the same cycle, so push into a full FIFO is legal alongside it.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign level_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/trng_postproc.sv
`default_nettype none
// ============================================================================
// Module      : trng_postproc
// Description : TRNG enable control, von Neumann debias, repetition health
//               test, word packing and buffered valid/ready read port.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_postproc
    import trng_pkg::*;
#(
    parameter int  WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int  FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int  WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int  REP_LIMIT     = DEF_REP_LIMIT,
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  trng_en,
    input  logic                  trng_out,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0]      level,
    output logic                  health_fail,
    input  logic                  clear_fail
);

    localparam int BIT_W  = $clog2(WORD_WIDTH);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);
    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);

    state_t                state_q, state_d;
    logic [WARM_W-1:0]     warm_q, warm_d;
    logic                  trng_en_q;
    logic                  health_fail_q, health_fail_d;
    logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
    logic                  last_q, last_d;
    logic                  phase_q, phase_d;
    logic                  first_q, first_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  pend_q, pend_d;
    logic [WORD_WIDTH-1:0] pend_word_q, pend_word_d;

    logic                  run;
    logic [REP_W-1:0]      rep_next;
    logic                  trip;
    logic                  pop;
    logic                  can_push;
    logic                  emit;
    logic                  complete;
    logic [WORD_WIDTH-1:0] word_fill;
    logic                  push;
    logic [WORD_WIDTH-1:0] push_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign rd_valid    = ~fifo_empty;
    assign pop         = rd_valid & rd_ready;
    assign can_push    = ~fifo_full | pop;
    assign trng_en     = trng_en_q;
    assign health_fail = health_fail_q;

    // Raw bits are consumed only while running and enabled; dropping enable wins over a trip.
    assign run      = (state_q == RUN) && enable;
    assign rep_next = ((rep_cnt_q != '0) && (trng_out == last_q)) ? rep_cnt_q + 1'b1 : REP_W'(1);
    assign trip     = run && (rep_next == REP_W'(REP_LIMIT));
    assign emit     = run & ~pend_q & phase_q & (first_q ^ trng_out);
    assign complete = emit && (bit_cnt_q == BIT_W'(WORD_WIDTH - 1));
    assign push     = run & ~trip & can_push & (pend_q | complete);

    always_comb begin
        word_fill            = word_q;
        word_fill[bit_cnt_q] = first_q;
        push_data            = pend_q ? pend_word_q : word_fill;
    end

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        last_d      = last_q;
        phase_d     = phase_q;
        first_d     = first_q;
        word_d      = word_q;
        bit_cnt_d   = bit_cnt_q;
        pend_d      = pend_q;
        pend_word_d = pend_word_q;
        if (!run || trip) begin
            rep_cnt_d   = '0;
            last_d      = 1'b0;
            phase_d     = 1'b0;
            first_d     = 1'b0;
            word_d      = '0;
            bit_cnt_d   = '0;
            pend_d      = 1'b0;
            pend_word_d = '0;
        end else begin
            rep_cnt_d = rep_next;
            last_d    = trng_out;
            // A word waiting for a FIFO slot freezes pair collection at the first-bit phase.
            if (pend_q) begin
                if (can_push) begin
                    pend_d = 1'b0;
                end
            end else if (!phase_q) begin
                first_d = trng_out;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (complete) begin
                    word_d    = '0;
                    bit_cnt_d = '0;
                    if (!can_push) begin
                        pend_d      = 1'b1;
                        pend_word_d = word_fill;
                    end
                end else if (emit) begin
                    word_d    = word_fill;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        warm_d        = '0;
        health_fail_d = health_fail_q;
        case (state_q)
            IDLE: begin
                if (enable && !health_fail_q) begin
                    state_d = WARMUP;
                end
            end
            WARMUP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (warm_q == WARM_W'(WARMUP_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (trip) begin
                    state_d       = FAIL;
                    health_fail_d = 1'b1;
                end
            end
            FAIL: begin
                if (clear_fail) begin
                    state_d       = IDLE;
                    health_fail_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            warm_q        <= '0;
            trng_en_q     <= 1'b0;
            health_fail_q <= 1'b0;
            rep_cnt_q     <= '0;
            last_q        <= 1'b0;
            phase_q       <= 1'b0;
            first_q       <= 1'b0;
            word_q        <= '0;
            bit_cnt_q     <= '0;
            pend_q        <= 1'b0;
            pend_word_q   <= '0;
        end else begin
            state_q       <= state_d;
            warm_q        <= warm_d;
            trng_en_q     <= (state_d == WARMUP) || (state_d == RUN);
            health_fail_q <= health_fail_d;
            rep_cnt_q     <= rep_cnt_d;
            last_q        <= last_d;
            phase_q       <= phase_d;
            first_q       <= first_d;
            word_q        <= word_d;
            bit_cnt_q     <= bit_cnt_d;
            pend_q        <= pend_d;
            pend_word_q   <= pend_word_d;
        end
    end

    trng_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (trip),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level),
        .head_o      (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_trng_postproc.sv
`default_nettype none
// ============================================================================
// Module      : tb_trng_postproc
// Description : Directed self-checking bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_postproc;

    localparam int W    = 32;
    localparam int D    = 4;
    localparam int WARM = 16;
    localparam int REP  = 32;
    localparam int LW   = $clog2(D) + 1;

    localparam int M_IDLE = 0;
    localparam int M_WARM = 1;
    localparam int M_RUN  = 2;
    localparam int M_FAIL = 3;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          enable     = 1'b0;
    logic          trng_out   = 1'b0;
    logic          rd_ready   = 1'b0;
    logic          clear_fail = 1'b0;
    logic          trng_en;
    logic          rd_valid;
    logic          health_fail;
    logic [W-1:0]  rd_data;
    logic [LW-1:0] level;

    int   errors = 0;
    int   checks = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    trng_postproc #(
        .WORD_WIDTH    (W),
        .FIFO_DEPTH    (D),
        .WARMUP_CYCLES (WARM),
        .REP_LIMIT     (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .trng_en     (trng_en),
        .trng_out    (trng_out),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .level       (level),
        .health_fail (health_fail),
        .clear_fail  (clear_fail)
    );

    // Reference model: raw bits, pairs, emitted bits and the FIFO held as plain queues.
    int           mst;
    int           wc;
    int           rep_len;
    logic         rep_last;
    logic         pair[$];
    logic         bits[$];
    logic         pend_v;
    logic [W-1:0] pend_w;
    logic [W-1:0] fifo[$];
    logic         hf;

    always @(posedge clk or negedge rst_n) begin : model
        logic         m_pop;
        logic         m_run;
        logic         m_trip;
        logic         m_can;
        logic         m_push;
        logic [W-1:0] pw;
        if (!rst_n) begin
            mst = M_IDLE; wc = 0; rep_len = 0; rep_last = 1'b0;
            pair.delete(); bits.delete(); fifo.delete();
            pend_v = 1'b0; pend_w = '0; hf = 1'b0;
        end else begin
            m_pop  = (fifo.size() > 0) && rd_ready;
            m_run  = (mst == M_RUN) && enable;
            m_trip = 1'b0;
            m_push = 1'b0;
            pw     = '0;
            if (m_run) begin
                if (rep_len > 0 && trng_out == rep_last) rep_len++;
                else rep_len = 1;
                rep_last = trng_out;
                m_trip   = (rep_len == REP);
            end
            m_can = (fifo.size() < D) || m_pop;
            if (m_run && !m_trip) begin
                if (pend_v) begin
                    if (m_can) begin
                        m_push = 1'b1;
                        pw     = pend_w;
                        pend_v = 1'b0;
                    end
                end else begin
                    pair.push_back(trng_out);
                    if (pair.size() == 2) begin
                        if (pair[0] != pair[1]) bits.push_back(pair[0]);
                        pair.delete();
                        if (bits.size() == W) begin
                            for (int i = 0; i < W; i++) pw[i] = bits[i];
                            bits.delete();
                            if (m_can) m_push = 1'b1;
                            else begin
                                pend_v = 1'b1;
                                pend_w = pw;
                            end
                        end
                    end
                end
            end
            if (m_trip) fifo.delete();
            else begin
                if (m_pop) void'(fifo.pop_front());
                if (m_push) fifo.push_back(pw);
            end
            if (!m_run || m_trip) begin
                pair.delete(); bits.delete();
                pend_v = 1'b0; rep_len = 0;
            end
            case (mst)
                M_IDLE: if (enable && !hf) begin mst = M_WARM; wc = 0; end
                M_WARM: begin
                    if (!enable) mst = M_IDLE;
                    else begin
                        wc++;
                        if (wc == WARM) mst = M_RUN;
                    end
                end
                M_RUN: begin
                    if (!enable) mst = M_IDLE;
                    else if (m_trip) begin mst = M_FAIL; hf = 1'b1; end
                end
                default: if (clear_fail) begin mst = M_IDLE; hf = 1'b0; end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_trng_en", 32'(trng_en), 32'((mst == M_WARM) || (mst == M_RUN)));
            chk("cyc_rd_valid", 32'(rd_valid), 32'(fifo.size() > 0));
            chk("cyc_rd_data", rd_data, (fifo.size() > 0) ? fifo[0] : '0);
            chk("cyc_level", 32'(level), 32'(fifo.size()));
            chk("cyc_health_fail", 32'(health_fail), 32'(hf));
        end
    end

    task automatic step(input logic en, input logic b, input logic rdy, input logic clr);
        enable     = en;
        trng_out   = b;
        rd_ready   = rdy;
        clear_fail = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic feed_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            if (w[i]) begin feed(1'b1); feed(1'b0); end
            else begin feed(1'b0); feed(1'b1); end
        end
    endtask

    // Warm-up bits are driven as 1 so an off-by-one RUN entry would corrupt the next word.
    task automatic warm();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("warm_trng_en", 32'(trng_en), 32'd1);
        repeat (WARM) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_trng_en"}, 32'(trng_en), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_health_fail"}, 32'(health_fail), 32'd0);
    endtask

    logic [W-1:0] wv [5];

    initial begin
        wv[0] = 32'hDEADBEEF; wv[1] = 32'h01234567; wv[2] = 32'h89ABCDEF;
        wv[3] = 32'h0F0F3C3C; wv[4] = 32'hA5A55A5A;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        @(posedge clk); #1;
        chk_reset("reset");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_trng_en", 32'(trng_en), 32'd0);

        warm();
        feed_word(32'h0);
        chk("t2_level", 32'(level), 32'd1);
        chk("t2_rd_valid", 32'(rd_valid), 32'd1);
        chk("t2_rd_data", rd_data, 32'h0);

        feed_word(32'hFFFFFFFF);
        feed(1'b0); feed(1'b0); feed(1'b1); feed(1'b1);
        chk("t3_level", 32'(level), 32'd2);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t3_head", rd_data, 32'hFFFFFFFF);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t3_empty", 32'(level), 32'd0);
        repeat (30) begin feed(1'b0); feed(1'b1); end
        chk("t3_no_extra_bits", 32'(level), 32'd0);
        feed(1'b0); feed(1'b1);
        chk("t3_word_done", 32'(level), 32'd1);
        chk("t3_word_zero", rd_data, 32'h0);

        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) feed_word(wv[k]);
        chk("t4_level_sat", 32'(level), 32'd4);
        chk("t4_head", rd_data, wv[0]);
        repeat (5) begin feed(1'b1); feed(1'b0); end
        chk("t4_stall_level", 32'(level), 32'd4);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_pend_push", 32'(level), 32'd4);
        chk("t4_head_b", rd_data, wv[1]);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_head_c", rd_data, wv[2]);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_head_d", rd_data, wv[3]);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_head_e", rd_data, wv[4]);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_drained", 32'(level), 32'd0);

        feed_word(32'h5A5AA5A5);
        feed(1'b0);
        repeat (REP - 1) feed(1'b1);
        chk("t5_pre_trip_hf", 32'(health_fail), 32'd0);
        chk("t5_pre_trip_level", 32'(level), 32'd1);
        feed(1'b1);
        chk("t5_hf", 32'(health_fail), 32'd1);
        chk("t5_trng_en", 32'(trng_en), 32'd0);
        chk("t5_flushed", 32'(level), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_sticky", 32'(health_fail), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_cleared", 32'(health_fail), 32'd0);
        chk("t5_idle_en", 32'(trng_en), 32'd0);
        warm();

        feed_word(32'hC3C3_1234);
        feed_word(32'h8001_7FFE);
        repeat (5) begin feed(1'b1); feed(1'b0); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_trng_en", 32'(trng_en), 32'd0);
        chk("t6_level", 32'(level), 32'd2);
        chk("t6_first", rd_data, 32'hC3C3_1234);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_second", rd_data, 32'h8001_7FFE);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_empty", 32'(level), 32'd0);
        warm();
        feed_word(32'h600D_F00D);
        chk("t6_clean_word", rd_data, 32'h600D_F00D);
        chk("t6_clean_level", 32'(level), 32'd1);

        feed(1'b1); feed(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
